mac_feeder: RTL and testbench
=============================

MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8, width of each operand.
REQ-002 SHALL have parameter DEPTH, default 4, operand-pair FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter CNT_WIDTH, default 8, width of the beat counter.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  upstream offers an operand pair.
REQ-008 in_ready  output  1  feeder can accept a pair this cycle.
REQ-009 in_a, in_b  input  IN_WIDTH  operand pair.
REQ-010 in_last  input  1  pair is the final term of the current dot product.
REQ-011 stall  input  1  downstream hold; suppresses issue.
REQ-012 mac_clr  output  1  one-cycle accumulator clear to the MAC.
REQ-013 mac_en  output  1  MAC accumulate enable.
REQ-014 mac_a, mac_b  output  IN_WIDTH  operands to the MAC.
REQ-015 done  output  1  one-cycle pulse; MAC sum is final during this cycle.
REQ-016 beat_count  output  CNT_WIDTH  pairs issued in the current or last dot product.

Function
REQ-017 Push occurs when in_valid && in_ready; in_ready SHALL equal !fifo_full (no same-cycle bypass when full).
REQ-018 FIFO SHALL store {a, b, last}; order preserved; pointers wrap modulo DEPTH.
REQ-019 FSM states SHALL be IDLE, CLEAR, RUN, DONE.
REQ-020 IDLE -> CLEAR when FIFO non-empty; otherwise stays IDLE.
REQ-021 CLEAR: mac_clr=1 for exactly one cycle, beat_count<=0; next state RUN unconditionally.
REQ-022 RUN: issue = !fifo_empty && !stall; on issue, mac_en=1, mac_a/mac_b = FIFO head (combinational, zero latency), head popped at the edge, beat_count increments.
REQ-023 RUN with FIFO empty or stall high: mac_en=0, mac_a/mac_b=0, no pop; state held.
REQ-024 Issue of an entry with last=1 SHALL transition RUN -> DONE.
REQ-025 DONE: done=1 for one cycle, mac_en=0; next state IDLE; pushes still accepted.
REQ-026 Minimum dot-product period = beats + 3 cycles (CLEAR, RUN beats, DONE, IDLE).
REQ-027 beat_count SHALL saturate at 2^CNT_WIDTH-1 and hold its value from DONE until the next CLEAR.
REQ-028 Simultaneous push and pop when not full SHALL leave occupancy unchanged; push while empty in RUN is issued no earlier than the next cycle.
REQ-029 mac_clr, mac_en, done SHALL be mutually exclusive in every cycle.
REQ-030 stall SHALL NOT affect CLEAR or DONE progression.

Reset
REQ-031 On rst low: state=IDLE, FIFO empty, beat_count=0, mac_clr=0, mac_en=0, done=0, mac_a=mac_b=0, in_ready=1.
REQ-032 Reset mid-dot-product SHALL discard all buffered pairs; no done pulse generated.
REQ-033 Release of rst SHALL take effect on the first rising clk edge after deassertion.

Structure
REQ-034 Shared package SHALL hold the FSM state enum (feeder_state_t) and the FIFO entry struct type.
REQ-035 FIFO SHALL be a separate sub-module, op_fifo, parameterised by width and DEPTH, exposing full/empty.

Verification
REQ-036 Single 3-pair product (1,2),(3,4),(5,6 last), stall=0 -> mac_clr cycle 1, mac_en cycles 2-4, done cycle 5, beat_count=3, MAC sum 44.
REQ-037 Push 5 pairs back-to-back with DEPTH=4 in IDLE -> in_ready low after 4th push until first pop; no pair lost or reordered.
REQ-038 stall high for 2 cycles mid-RUN -> mac_en low those 2 cycles, done delayed 2 cycles, beat_count unchanged.
REQ-039 Two products queued (2 pairs then 1 pair) -> two done pulses, beat_count 2 then 1, mac_clr pulsed before each.
REQ-040 rst asserted during RUN after 1 of 3 beats -> outputs zero immediately, FIFO empty, in_ready=1, no done.
REQ-041 CNT_WIDTH=2, 5-pair product -> beat_count saturates at 3, done still issued.

Source files
------------

// File: rtl/mac_feeder_pkg.sv
// rtl/mac_feeder_pkg.sv - shared types for the MAC operand feeder
package mac_feeder_pkg;

  // Widest operand a FIFO entry can carry; IN_WIDTH of the feeder must not exceed this.
  localparam int unsigned MAX_IN_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_t;

  // One buffered term of a dot product. Operands are zero-extended into the
  // fixed-width fields; unused upper bits are constant and trim away.
  typedef struct packed {
    logic [MAX_IN_WIDTH-1:0] a;
    logic [MAX_IN_WIDTH-1:0] b;
    logic                    last;
  } fifo_entry_t;

endpackage

// File: rtl/op_fifo.sv
// rtl/op_fifo.sv - operand-pair FIFO with full/empty flags and show-ahead head
module op_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             do_push, do_pop;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign rdata   = mem_q[rptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Advance pointers on accepted push/pop; they wrap naturally modulo 2*DEPTH.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PW'(1);
    if (do_pop)  rptr_d = rptr_q + PW'(1);
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mac_feeder.sv
// rtl/mac_feeder.sv - buffers operand pairs and sequences clear/accumulate/done for a MAC
module mac_feeder #(
  parameter int IN_WIDTH  = 8,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_a,
  input  logic [IN_WIDTH-1:0]  in_b,
  input  logic                 in_last,
  input  logic                 stall,
  output logic                 mac_clr,
  output logic                 mac_en,
  output logic [IN_WIDTH-1:0]  mac_a,
  output logic [IN_WIDTH-1:0]  mac_b,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] beat_count
);

  import mac_feeder_pkg::*;

  feeder_state_t        state_q, state_d;
  logic [CNT_WIDTH-1:0] beat_q, beat_d;
  fifo_entry_t          wr_entry, head;
  logic                 fifo_full, fifo_empty, pop;

  // Pack the incoming pair into the shared entry layout.
  always_comb begin
    wr_entry      = '0;
    wr_entry.a    = MAX_IN_WIDTH'(in_a);
    wr_entry.b    = MAX_IN_WIDTH'(in_b);
    wr_entry.last = in_last;
  end

  op_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready   = !fifo_full;
  assign beat_count = beat_q;

  // Next-state and output decode; the three strobes come from distinct states so never overlap.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    done    = 1'b0;
    pop     = 1'b0;
    mac_a   = '0;
    mac_b   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        mac_clr = 1'b1;
        beat_d  = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!fifo_empty && !stall) begin
          mac_en = 1'b1;
          pop    = 1'b1;
          mac_a  = IN_WIDTH'(head.a);
          mac_b  = IN_WIDTH'(head.b);
          if (beat_q != {CNT_WIDTH{1'b1}}) beat_d = beat_q + CNT_WIDTH'(1);
          if (head.last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and beat counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// tb/tb_mac_feeder.sv - directed self-checking bench for mac_feeder
module tb_mac_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_last, stall, in_ready;
  logic [7:0] in_a, in_b, mac_a, mac_b, beat_count;
  logic       mac_clr, mac_en, done;

  logic       in_valid2, in_last2, stall2, in_ready2;
  logic [7:0] in_a2, in_b2, mac_a2, mac_b2;
  logic       mac_clr2, mac_en2, done2;
  logic [1:0] beat_count2;

  int vectors = 0;
  int errors  = 0;
  int acc     = 0;

  typedef struct {
    bit       v;
    int       a;
    int       b;
    bit       l;
    bit       s;
    bit       rdy;
    bit [2:0] ctl;
    int       ea;
    int       eb;
    int       bt;
  } row_t;

  mac_feeder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .stall(stall),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .done(done), .beat_count(beat_count)
  );

  mac_feeder #(.IN_WIDTH(8), .DEPTH(4), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2), .in_last(in_last2), .stall(stall2),
    .mac_clr(mac_clr2), .mac_en(mac_en2), .mac_a(mac_a2), .mac_b(mac_b2),
    .done(done2), .beat_count(beat_count2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mac_clr)     acc <= 0;
    else if (mac_en) acc <= acc + int'(mac_a) * int'(mac_b);
  end

  function automatic row_t mk(bit v, int a, int b, bit l, bit s, bit rdy,
                              bit [2:0] ctl, int ea, int eb, int bt);
    row_t r;
    r.v = v; r.a = a; r.b = b; r.l = l; r.s = s;
    r.rdy = rdy; r.ctl = ctl; r.ea = ea; r.eb = eb; r.bt = bt;
    return r;
  endfunction

  task automatic test_reset;
    in_valid = 0; in_a = 0; in_b = 0; in_last = 0; stall = 0;
    in_valid2 = 0; in_a2 = 0; in_b2 = 0; in_last2 = 0; stall2 = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    vectors += 5;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    if ({mac_clr, mac_en, done} !== 3'b000) begin errors++; $display("FAIL reset_ctl got %b exp 000", {mac_clr, mac_en, done}); end
    if (mac_a !== 8'd0 || mac_b !== 8'd0) begin errors++; $display("FAIL reset_ops got %0d,%0d exp 0,0", mac_a, mac_b); end
    if (beat_count !== 8'd0) begin errors++; $display("FAIL reset_beat got %0d exp 0", beat_count); end
    if (in_ready2 !== 1'b1 || beat_count2 !== 2'd0) begin errors++; $display("FAIL reset_dut2 got rdy %b beat %0d exp 1,0", in_ready2, beat_count2); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    row_t t[$];
    t.push_back(mk(1, 1, 2, 0, 0, 1, 3'b000, 0, 0, 0));
    t.push_back(mk(1, 3, 4, 0, 0, 1, 3'b000, 0, 0, 0));
    t.push_back(mk(1, 5, 6, 1, 0, 1, 3'b100, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b010, 1, 2, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b010, 3, 4, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b010, 5, 6, 2));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b001, 0, 0, 3));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 3));
    foreach (t[i]) begin
      in_valid = t[i].v; in_a = 8'(t[i].a); in_b = 8'(t[i].b); in_last = t[i].l; stall = t[i].s;
      #1;
      vectors += 4;
      if (in_ready !== t[i].rdy) begin errors++; $display("FAIL single_ready cyc %0d got %b exp %b", i, in_ready, t[i].rdy); end
      if ({mac_clr, mac_en, done} !== t[i].ctl) begin errors++; $display("FAIL single_ctl cyc %0d got %b exp %b", i, {mac_clr, mac_en, done}, t[i].ctl); end
      if (mac_a !== 8'(t[i].ea) || mac_b !== 8'(t[i].eb)) begin errors++; $display("FAIL single_ops cyc %0d got %0d,%0d exp %0d,%0d", i, mac_a, mac_b, t[i].ea, t[i].eb); end
      if (beat_count !== 8'(t[i].bt)) begin errors++; $display("FAIL single_beat cyc %0d got %0d exp %0d", i, beat_count, t[i].bt); end
      @(negedge clk);
    end
    vectors++;
    if (acc !== 44) begin errors++; $display("FAIL single_sum got %0d exp 44", acc); end
  endtask

  task automatic test_stall;
    row_t t[$];
    t.push_back(mk(1, 2, 3, 0, 0, 1, 3'b000, 0, 0, 3));
    t.push_back(mk(1, 4, 5, 0, 0, 1, 3'b000, 0, 0, 3));
    t.push_back(mk(1, 6, 7, 1, 0, 1, 3'b100, 0, 0, 3));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b010, 2, 3, 0));
    t.push_back(mk(0, 0, 0, 0, 1, 1, 3'b000, 0, 0, 1));
    t.push_back(mk(0, 0, 0, 0, 1, 1, 3'b000, 0, 0, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b010, 4, 5, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b010, 6, 7, 2));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b001, 0, 0, 3));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 3));
    foreach (t[i]) begin
      in_valid = t[i].v; in_a = 8'(t[i].a); in_b = 8'(t[i].b); in_last = t[i].l; stall = t[i].s;
      #1;
      vectors += 4;
      if (in_ready !== t[i].rdy) begin errors++; $display("FAIL stall_ready cyc %0d got %b exp %b", i, in_ready, t[i].rdy); end
      if ({mac_clr, mac_en, done} !== t[i].ctl) begin errors++; $display("FAIL stall_ctl cyc %0d got %b exp %b", i, {mac_clr, mac_en, done}, t[i].ctl); end
      if (mac_a !== 8'(t[i].ea) || mac_b !== 8'(t[i].eb)) begin errors++; $display("FAIL stall_ops cyc %0d got %0d,%0d exp %0d,%0d", i, mac_a, mac_b, t[i].ea, t[i].eb); end
      if (beat_count !== 8'(t[i].bt)) begin errors++; $display("FAIL stall_beat cyc %0d got %0d exp %0d", i, beat_count, t[i].bt); end
      @(negedge clk);
    end
    vectors++;
    if (acc !== 68) begin errors++; $display("FAIL stall_sum got %0d exp 68", acc); end
  endtask

  task automatic test_backpressure;
    row_t t[$];
    t.push_back(mk(1, 1, 11, 0, 1, 1, 3'b000, 0, 0, 3));
    t.push_back(mk(1, 2, 12, 0, 1, 1, 3'b000, 0, 0, 3));
    t.push_back(mk(1, 3, 13, 0, 1, 1, 3'b100, 0, 0, 3));
    t.push_back(mk(1, 4, 14, 0, 1, 1, 3'b000, 0, 0, 0));
    t.push_back(mk(1, 5, 15, 1, 1, 0, 3'b000, 0, 0, 0));
    t.push_back(mk(1, 5, 15, 1, 1, 0, 3'b000, 0, 0, 0));
    t.push_back(mk(1, 5, 15, 1, 0, 0, 3'b010, 1, 11, 0));
    t.push_back(mk(1, 5, 15, 1, 0, 1, 3'b010, 2, 12, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b010, 3, 13, 2));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b010, 4, 14, 3));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b010, 5, 15, 4));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b001, 0, 0, 5));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 5));
    foreach (t[i]) begin
      in_valid = t[i].v; in_a = 8'(t[i].a); in_b = 8'(t[i].b); in_last = t[i].l; stall = t[i].s;
      #1;
      vectors += 4;
      if (in_ready !== t[i].rdy) begin errors++; $display("FAIL bp_ready cyc %0d got %b exp %b", i, in_ready, t[i].rdy); end
      if ({mac_clr, mac_en, done} !== t[i].ctl) begin errors++; $display("FAIL bp_ctl cyc %0d got %b exp %b", i, {mac_clr, mac_en, done}, t[i].ctl); end
      if (mac_a !== 8'(t[i].ea) || mac_b !== 8'(t[i].eb)) begin errors++; $display("FAIL bp_ops cyc %0d got %0d,%0d exp %0d,%0d", i, mac_a, mac_b, t[i].ea, t[i].eb); end
      if (beat_count !== 8'(t[i].bt)) begin errors++; $display("FAIL bp_beat cyc %0d got %0d exp %0d", i, beat_count, t[i].bt); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    row_t t[$];
    t.push_back(mk(1, 1, 1, 0, 0, 1, 3'b000, 0, 0, 5));
    t.push_back(mk(1, 2, 2, 1, 0, 1, 3'b000, 0, 0, 5));
    t.push_back(mk(1, 3, 3, 1, 0, 1, 3'b100, 0, 0, 5));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b010, 1, 1, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b010, 2, 2, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b001, 0, 0, 2));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 2));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b100, 0, 0, 2));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b010, 3, 3, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b001, 0, 0, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 1));
    foreach (t[i]) begin
      in_valid = t[i].v; in_a = 8'(t[i].a); in_b = 8'(t[i].b); in_last = t[i].l; stall = t[i].s;
      #1;
      vectors += 4;
      if (in_ready !== t[i].rdy) begin errors++; $display("FAIL b2b_ready cyc %0d got %b exp %b", i, in_ready, t[i].rdy); end
      if ({mac_clr, mac_en, done} !== t[i].ctl) begin errors++; $display("FAIL b2b_ctl cyc %0d got %b exp %b", i, {mac_clr, mac_en, done}, t[i].ctl); end
      if (mac_a !== 8'(t[i].ea) || mac_b !== 8'(t[i].eb)) begin errors++; $display("FAIL b2b_ops cyc %0d got %0d,%0d exp %0d,%0d", i, mac_a, mac_b, t[i].ea, t[i].eb); end
      if (beat_count !== 8'(t[i].bt)) begin errors++; $display("FAIL b2b_beat cyc %0d got %0d exp %0d", i, beat_count, t[i].bt); end
      @(negedge clk);
    end
    vectors++;
    if (acc !== 9) begin errors++; $display("FAIL b2b_sum got %0d exp 9", acc); end
  endtask

  task automatic test_reset_mid;
    row_t t[$];
    t.push_back(mk(1, 1, 2, 0, 0, 1, 3'b000, 0, 0, 1));
    t.push_back(mk(1, 3, 4, 0, 0, 1, 3'b000, 0, 0, 1));
    t.push_back(mk(1, 5, 6, 1, 0, 1, 3'b100, 0, 0, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b010, 1, 2, 0));
    foreach (t[i]) begin
      in_valid = t[i].v; in_a = 8'(t[i].a); in_b = 8'(t[i].b); in_last = t[i].l; stall = t[i].s;
      #1;
      vectors += 2;
      if ({mac_clr, mac_en, done} !== t[i].ctl) begin errors++; $display("FAIL rmid_ctl cyc %0d got %b exp %b", i, {mac_clr, mac_en, done}, t[i].ctl); end
      if (mac_a !== 8'(t[i].ea) || mac_b !== 8'(t[i].eb)) begin errors++; $display("FAIL rmid_ops cyc %0d got %0d,%0d exp %0d,%0d", i, mac_a, mac_b, t[i].ea, t[i].eb); end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    vectors += 4;
    if ({mac_clr, mac_en, done} !== 3'b000) begin errors++; $display("FAIL rmid_async_ctl got %b exp 000", {mac_clr, mac_en, done}); end
    if (mac_a !== 8'd0 || mac_b !== 8'd0) begin errors++; $display("FAIL rmid_async_ops got %0d,%0d exp 0,0", mac_a, mac_b); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_async_ready got %b exp 1", in_ready); end
    if (beat_count !== 8'd0) begin errors++; $display("FAIL rmid_async_beat got %0d exp 0", beat_count); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors += 2;
      if ({mac_clr, mac_en, done} !== 3'b000) begin errors++; $display("FAIL rmid_after_ctl cyc %0d got %b exp 000", c, {mac_clr, mac_en, done}); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_after_ready cyc %0d got %b exp 1", c, in_ready); end
      @(negedge clk);
    end
  endtask

  task automatic test_saturate;
    row_t t[$];
    t.push_back(mk(1, 1, 1, 0, 0, 1, 3'b000, 0, 0, 0));
    t.push_back(mk(1, 2, 2, 0, 0, 1, 3'b000, 0, 0, 0));
    t.push_back(mk(1, 3, 3, 0, 0, 1, 3'b100, 0, 0, 0));
    t.push_back(mk(1, 4, 4, 0, 0, 1, 3'b010, 1, 1, 0));
    t.push_back(mk(1, 5, 5, 1, 0, 1, 3'b010, 2, 2, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b010, 3, 3, 2));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b010, 4, 4, 3));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b010, 5, 5, 3));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b001, 0, 0, 3));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 3));
    foreach (t[i]) begin
      in_valid2 = t[i].v; in_a2 = 8'(t[i].a); in_b2 = 8'(t[i].b); in_last2 = t[i].l; stall2 = t[i].s;
      #1;
      vectors += 4;
      if (in_ready2 !== t[i].rdy) begin errors++; $display("FAIL sat_ready cyc %0d got %b exp %b", i, in_ready2, t[i].rdy); end
      if ({mac_clr2, mac_en2, done2} !== t[i].ctl) begin errors++; $display("FAIL sat_ctl cyc %0d got %b exp %b", i, {mac_clr2, mac_en2, done2}, t[i].ctl); end
      if (mac_a2 !== 8'(t[i].ea) || mac_b2 !== 8'(t[i].eb)) begin errors++; $display("FAIL sat_ops cyc %0d got %0d,%0d exp %0d,%0d", i, mac_a2, mac_b2, t[i].ea, t[i].eb); end
      if (beat_count2 !== 2'(t[i].bt)) begin errors++; $display("FAIL sat_beat cyc %0d got %0d exp %0d", i, beat_count2, t[i].bt); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_stall;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_saturate;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
